// File: rtl/cache_assoc_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_assoc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL,
      RESP
   } state_t;

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // Tag is whatever remains above the word offset and the set index.
   function automatic int tag_bits(input int addr_w, input int sets);
      return addr_w - 2 - index_bits(sets);
   endfunction

endpackage

// File: rtl/cache_lru_set.sv
// Age-based LRU state for one cache set: touch update and victim select.
// Direct-mapped configurations (WAYS=1) keep no state at all.
module cache_lru_set
   import cache_assoc_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = way_bits(WAYS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             touch,
   input  logic [WAY_W-1:0] touch_way,
   output logic [WAY_W-1:0] victim
);

   if (WAYS == 1) begin : g_direct
      assign victim = '0;
      wire unused_lru = &{1'b0, clk, reset, touch, touch_way};
   end else begin : g_lru
      logic [WAY_W-1:0] age_q [WAYS];
      logic [WAY_W-1:0] oldest_age;

      // Ages start cleared, so "<=" (not "<") lets tied ways spread apart on first use.
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= '0;
         end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == touch_way)
                  age_q[w] <= '0;
               else if (age_q[w] <= age_q[touch_way] && age_q[w] != '1)
                  age_q[w] <= age_q[w] + 1'b1;
            end
         end
      end

      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
         victim     = '0;
         oldest_age = age_q[0];
         for (int w = 1; w < WAYS; w++) begin
            if (age_q[w] > oldest_age) begin
               victim     = WAY_W'(w);
               oldest_age = age_q[w];
            end
         end
      end
   end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative, write-back, write-allocate cache with a multi-cycle miss FSM.
// Define CACHE_WB_STATS_EN to add the total_writebacks statistics port.
module cache_assoc_wb
   import cache_assoc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              access,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic              Write_Enable,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] Data_Out,
   output logic              Hit_Miss,
   output logic [CNT_W-1:0]  total_accesses,
   output logic [CNT_W-1:0]  total_misses,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef CACHE_WB_STATS_EN
   ,
   output logic [CNT_W-1:0]  total_writebacks
`endif
);

   localparam int IDX_W = index_bits(SETS);
   localparam int TAG_W = tag_bits(ADDR_W, SETS);
   localparam int WAY_W = way_bits(WAYS);

   state_t state_q, state_d;

   logic [ADDR_W-3:0] req_word_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic              req_we_q;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;

   logic [WAYS-1:0]   valid_q   [SETS];
   logic [WAYS-1:0]   dirty_q   [SETS];
   logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
   logic [DATA_W-1:0] data_mem  [SETS][WAYS];

   logic              accept, hit, free, victim_dirty, lru_touch;
   logic [WAY_W-1:0]  hit_way, free_way, victim_sel, victim_q, lru_way;
   logic [WAY_W-1:0]  lru_victim [SETS];
   logic [DATA_W-1:0] fill_word;

   wire unused_addr_lsb = &{1'b0, Address[1:0]};

   assign accept    = access & ready;
   assign idx       = req_word_q[IDX_W-1:0];
   assign tag       = req_word_q[IDX_W +: TAG_W];
   assign fill_word = req_we_q ? req_wdata_q : mem_rdata;

   // Descending scan leaves the lowest-index match in hit_way / free_way.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   assign victim_sel   = free ? free_way : lru_victim[idx];
   assign victim_dirty = valid_q[idx][victim_sel] & dirty_q[idx][victim_sel];

   assign lru_touch = (state_q == LOOKUP && hit) || (state_q == FILL && mem_ack);
   assign lru_way   = (state_q == LOOKUP) ? hit_way : victim_q;

   for (genvar s = 0; s < SETS; s++) begin : g_set
      cache_lru_set #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
         .clk       (clk),
         .reset     (reset),
         .touch     (lru_touch && (idx == IDX_W'(s))),
         .touch_way (lru_way),
         .victim    (lru_victim[s])
      );
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LOOKUP;
         LOOKUP:  state_d = hit ? IDLE : (victim_dirty ? WB : FILL);
         WB:      if (mem_ack) state_d = FILL;
         FILL:    if (mem_ack) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_mem[idx][victim_q], idx, 2'b00};
            mem_wdata = data_mem[idx][victim_q];
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_word_q, 2'b00};
         end
         default: ;
      endcase
   end

   // Control state and visible outputs; ready returns the cycle after done.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready          <= 1'b1;
         done           <= 1'b0;
         Hit_Miss       <= 1'b0;
         Data_Out       <= '0;
         total_accesses <= '0;
         total_misses   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
`ifdef CACHE_WB_STATS_EN
         total_writebacks <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (done) ready <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  ready          <= 1'b0;
                  total_accesses <= sat_inc(total_accesses);
               end
            end
            LOOKUP: begin
               if (hit) begin
                  done     <= 1'b1;
                  Hit_Miss <= 1'b1;
                  Data_Out <= req_we_q ? req_wdata_q : data_mem[idx][hit_way];
                  if (req_we_q) dirty_q[idx][hit_way] <= 1'b1;
               end else begin
                  total_misses <= sat_inc(total_misses);
               end
            end
            WB: begin
`ifdef CACHE_WB_STATS_EN
               if (mem_ack) total_writebacks <= sat_inc(total_writebacks);
`endif
            end
            FILL: begin
               if (mem_ack) begin
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= req_we_q;
                  done                   <= 1'b1;
                  Hit_Miss               <= 1'b0;
                  Data_Out               <= fill_word;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: tag/data arrays carry no reset; valid bits alone make their contents meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_word_q  <= Address[ADDR_W-1:2];
         req_wdata_q <= Write_Data;
         req_we_q    <= Write_Enable;
      end
      if (state_q == LOOKUP && !hit) victim_q <= victim_sel;
      if (state_q == LOOKUP && hit && req_we_q) data_mem[idx][hit_way] <= req_wdata_q;
      if (state_q == FILL && mem_ack) begin
         tag_mem[idx][victim_q]  <= tag;
         data_mem[idx][victim_q] <= fill_word;
      end
   end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: a recency-stamped line list predicts responses
// and memory traffic; monitors compare whenever done or a memory request appears.
module tb_cache_assoc_wb;

   localparam int SETS  = 16;
   localparam int WAYS  = 2;
   localparam int IDX_B = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        access;
   logic [31:0] Address;
   logic [31:0] Write_Data;
   logic        Write_Enable;
   logic        ready, done, Hit_Miss;
   logic [31:0] Data_Out;
   logic [31:0] total_accesses, total_misses;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
`ifdef CACHE_WB_STATS_EN
   logic [31:0] total_writebacks;
`endif

   cache_assoc_wb dut (
      .clk            (clk),
      .reset          (reset),
      .access         (access),
      .Address        (Address),
      .Write_Data     (Write_Data),
      .Write_Enable   (Write_Enable),
      .ready          (ready),
      .done           (done),
      .Data_Out       (Data_Out),
      .Hit_Miss       (Hit_Miss),
      .total_accesses (total_accesses),
      .total_misses   (total_misses),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
`ifdef CACHE_WB_STATS_EN
      ,
      .total_writebacks (total_writebacks)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          set;
      logic [31:0] tag;
      logic [31:0] data;
      bit          dirty;
      int          stamp;
   } line_t;

   typedef struct {
      logic [31:0] data;
      bit          hit;
      int          acc;
      int          miss;
      int          wbs;
   } resp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mtx_t;

   line_t lines[$];
   resp_t resp_exp[$];
   mtx_t  mem_exp[$];
   int    stamp, acc, miss, wbs;
   int    vectors, miscompares;
   bit    mem_stall;
   bit    junk_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: lines of a set ordered by last-use stamp; the smallest stamp is evicted.
   task automatic model_access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                               output bit hit);
      int          s, found, cnt, oldest;
      logic [31:0] t;
      resp_t       r;
      mtx_t        m;
      line_t       l;
      s      = int'((addr >> 2) % SETS);
      t      = addr >> (2 + IDX_B);
      found  = -1;
      cnt    = 0;
      oldest = -1;
      stamp++;
      acc++;
      foreach (lines[i]) begin
         if (lines[i].set == s) begin
            cnt++;
            if (lines[i].tag == t) found = i;
            if (oldest < 0 || lines[i].stamp < lines[oldest].stamp) oldest = i;
         end
      end
      if (found >= 0) begin
         hit = 1'b1;
         if (we) begin
            lines[found].data  = wd;
            lines[found].dirty = 1'b1;
         end
         lines[found].stamp = stamp;
         r.data = lines[found].data;
      end else begin
         hit = 1'b0;
         miss++;
         if (cnt == WAYS) begin
            if (lines[oldest].dirty) begin
               m.we    = 1'b1;
               m.addr  = (lines[oldest].tag << (2 + IDX_B)) | (s << 2);
               m.wdata = lines[oldest].data;
               mem_exp.push_back(m);
               wbs++;
            end
            lines.delete(oldest);
         end
         m.we    = 1'b0;
         m.addr  = addr & ~32'h3;
         m.wdata = '0;
         mem_exp.push_back(m);
         l.set   = s;
         l.tag   = t;
         l.data  = we ? wd : ((addr & ~32'h3) ^ 32'hA5A5_0000);
         l.dirty = we;
         l.stamp = stamp;
         lines.push_back(l);
         r.data  = l.data;
      end
      r.hit  = hit;
      r.acc  = acc;
      r.miss = miss;
      r.wbs  = wbs;
      resp_exp.push_back(r);
   endtask

   task automatic model_reset();
      lines.delete();
      resp_exp.delete();
      mem_exp.delete();
      acc  = 0;
      miss = 0;
      wbs  = 0;
   endtask

   // Issue one access from a negedge and return at the negedge after ready rises.
   task automatic issue(input logic [31:0] addr, input bit we, input logic [31:0] wd);
      bit exp_hit;
      int cyc;
      cyc = 0;
      while (!ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("ready_wait", ready, 1);
      model_access(addr, we, wd, exp_hit);
      access       = 1'b1;
      Address      = addr;
      Write_Enable = we;
      Write_Data   = wd;
      @(negedge clk);
      access = 1'b0;
      check("ready_fall", ready, 0);
      cyc = 0;
      while (!done && cyc < 200) begin
         access       = junk_en && ($urandom_range(0, 3) == 0);
         Address      = $urandom;
         Write_Enable = 1'($urandom);
         Write_Data   = $urandom;
         @(negedge clk);
         access = 1'b0;
         cyc++;
      end
      check("done_seen", done, 1);
      if (exp_hit) check("hit_latency", cyc, 1);
      @(negedge clk);
      check("ready_rise", ready, 1);
   endtask

   // Response monitor.
   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clk);
         if (done) begin
            if (resp_exp.size() == 0) begin
               check("spurious_done", done, 0);
            end else begin
               r = resp_exp.pop_front();
               check("Data_Out", Data_Out, r.data);
               check("Hit_Miss", Hit_Miss, r.hit);
               check("total_accesses", total_accesses, r.acc);
               check("total_misses", total_misses, r.miss);
`ifdef CACHE_WB_STATS_EN
               check("total_writebacks", total_writebacks, r.wbs);
`endif
            end
         end
      end
   end

   // Backing memory: checks each request, acks ~3 cycles later with addr ^ A5A5_0000.
   initial begin : memory
      mtx_t        m;
      logic [31:0] a;
      int          cnt;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            a = mem_addr;
            if (mem_exp.size() == 0) begin
               check("spurious_mem_req", mem_req, 0);
            end else begin
               m = mem_exp.pop_front();
               check("mem_we", mem_we, m.we);
               check("mem_addr", mem_addr, m.addr);
               if (m.we) check("mem_wdata", mem_wdata, m.wdata);
            end
            cnt = 0;
            while (cnt < 2 || mem_stall) begin
               @(negedge clk);
               cnt++;
            end
            mem_ack   = 1'b1;
            mem_rdata = a ^ 32'hA5A5_0000;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_idle_reset_state(input string tag);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_hit_miss"}, Hit_Miss, 0);
      check({tag, "_data_out"}, Data_Out, 0);
      check({tag, "_acc"}, total_accesses, 0);
      check({tag, "_miss"}, total_misses, 0);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
`ifdef CACHE_WB_STATS_EN
      check({tag, "_wbs"}, total_writebacks, 0);
`endif
   endtask

   initial begin : stimulus
      int cyc;
      logic [31:0] a;
      vectors      = 0;
      miscompares  = 0;
      stamp        = 0;
      mem_stall    = 1'b0;
      junk_en      = 1'b1;
      reset        = 1'b1;
      access       = 1'b0;
      Address      = '0;
      Write_Data   = '0;
      Write_Enable = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle_reset_state("rst");

      // Cold miss then hit on the same word.
      issue(32'd12, 1'b0, '0);
      check("s1_data", Data_Out, 32'hA5A5_000C);
      check("s1_miss", Hit_Miss, 0);
      issue(32'd12, 1'b0, '0);
      check("s1_rehit", Hit_Miss, 1);

      // Write-allocate then read back the written word.
      issue(32'd60, 1'b1, 32'hBBBB_BBBB);
      issue(32'd60, 1'b0, '0);
      check("s2_data", Data_Out, 32'hBBBB_BBBB);

      // Three tags in set 15: the dirty line at 60 is written back.
      issue(32'd60, 1'b1, 32'hBBBB_BBBB);
      issue(32'd124, 1'b0, '0);
      issue(32'd188, 1'b0, '0);
      issue(32'd124, 1'b0, '0);
      check("s3_hit124", Hit_Miss, 1);

      // Recency order in set 3 decides the clean victim.
      issue(32'd12, 1'b0, '0);
      issue(32'd76, 1'b0, '0);
      issue(32'd12, 1'b0, '0);
      issue(32'd140, 1'b0, '0);
      issue(32'd12, 1'b0, '0);
      issue(32'd76, 1'b0, '0);
      check("s4_miss76", Hit_Miss, 0);

      // Reset while the refill is outstanding, then a late ack.
      mem_stall = 1'b1;
      begin
         bit h;
         model_access(32'd204, 1'b0, '0, h);
      end
      access  = 1'b1;
      Address = 32'd204;
      Write_Enable = 1'b0;
      @(negedge clk);
      access = 1'b0;
      cyc = 0;
      while (!(mem_req && !mem_we) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("s5_fill_req", mem_req, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_idle_reset_state("s5_abort");
      mem_stall = 1'b0;
      repeat (8) @(negedge clk);
      check("s5_late_ack_ready", ready, 1);
      check("s5_late_ack_acc", total_accesses, 0);
      check("s5_late_ack_req", mem_req, 0);
      issue(32'd12, 1'b0, '0);
      check("s5_read12_miss", Hit_Miss, 0);
      check("s5_read12_misses", total_misses, 1);

      // Random traffic over a few tags of four sets to force conflicts and writebacks.
      for (int n = 0; n < 300; n++) begin
         a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
         issue(a, 1'($urandom), $urandom);
      end

      repeat (10) @(negedge clk);
      check("resp_queue_drained", resp_exp.size(), 0);
      check("mem_queue_drained", mem_exp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
